// File: rtl/fetch_pkg.sv
// Shared opcodes, fetch state encodings and BO bit positions for the fetch stage.
package fetch_pkg;

  localparam logic [5:0] OP_B    = 6'd18;
  localparam logic [5:0] OP_BC   = 6'd16;
  localparam logic [5:0] OP_BCLR = 6'd19;
  localparam logic [9:0] XO_BCLR = 10'd16;

  localparam logic [0:0] FETCH_RUN     = 1'b0;
  localparam logic [0:0] FETCH_WAIT_BR = 1'b1;

  localparam int BO_UNCOND   = 4;
  localparam int BO_COND_VAL = 3;

  // Primary opcode 19 is shared with CR-logic ops; only the bclr extended opcode halts fetch.
  function automatic logic is_branch(input logic [31:0] w);
    logic [5:0] op;
    op = w[31:26];
    return (op == OP_B) || (op == OP_BC) || ((op == OP_BCLR) && (w[10:1] == XO_BCLR));
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// QDEPTH-entry FIFO of {pc, instr} with flush and an empty-queue bypass path.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int PC_W   = 19,
  parameter int QDEPTH = 2,
  localparam int CW    = $clog2(QDEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_vld,
  input  logic [PC_W-1:0] in_pc,
  input  logic [31:0]     in_instr,
  input  logic            pop,
  output logic            out_vld,
  output logic [PC_W-1:0] out_pc,
  output logic [31:0]     out_instr,
  output logic [CW-1:0]   count
);

  localparam int PW = $clog2(QDEPTH);

  logic [PC_W-1:0] pc_mem    [QDEPTH];
  logic [31:0]     instr_mem [QDEPTH];
  logic [PW-1:0]   rd_ptr, wr_ptr;
  logic            empty, push, deq;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(QDEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty     = (count == '0);
  assign out_vld   = !empty || in_vld;
  assign out_pc    = empty ? in_pc : pc_mem[rd_ptr];
  assign out_instr = empty ? in_instr : instr_mem[rd_ptr];
  assign deq       = pop && !empty;
  // An arriving word consumed straight through the bypass is never stored.
  assign push      = in_vld && !(pop && empty);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= nxt(wr_ptr);
      if (deq)  rd_ptr <= nxt(rd_ptr);
      if (push && !deq)      count <= count + 1'b1;
      else if (deq && !push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]    <= in_pc;
      instr_mem[wr_ptr] <= in_instr;
    end
  end

endmodule

// File: rtl/fetch.sv
// Instruction-fetch stage: BRAM address issue, word queue, branch halt/redirect.
// Define FETCH_PERF_EN to add br_count/taken_count/stall_cycles counters.
module fetch
  import fetch_pkg::*;
#(
  parameter int          PC_W     = 19,
  parameter int unsigned RESET_PC = 0,
  parameter int          QDEPTH   = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic [PC_W-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  input  logic            stall,
  output logic            decode_en,
  output logic [31:0]     instr,
  output logic [PC_W-1:0] pc,
  input  logic            branch,
  input  logic            bclr,
  input  logic [PC_W-1:0] b_addr,
  input  logic [4:0]      b_cond,
  input  logic            cond_bit,
  input  logic [31:0]     lr
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]     br_count,
  output logic [31:0]     taken_count,
  output logic [31:0]     stall_cycles
`endif
);

  localparam int CW = $clog2(QDEPTH + 1);
  localparam int OW = CW + 1;

  logic [0:0]      state;
  logic [PC_W-1:0] fetch_pc;
  logic            vld_p1;
  logic [PC_W-1:0] pc_p1;
  logic            q_vld;
  logic [PC_W-1:0] q_pc;
  logic [31:0]     q_instr;
  logic [CW-1:0]   q_count;
  logic            run, pop, br_pop, issue, resolve, taken;
  logic [PC_W-1:0] target;
  logic            unused_bits;

  assign unused_bits = ^{lr[31:PC_W+2], lr[1:0], b_cond[2:0]};

  assign run     = (state == FETCH_RUN);
  assign pop     = run && q_vld && !stall;
  assign br_pop  = pop && is_branch(q_instr);
  // Occupancy after this cycle's pop, counting the word still in the BRAM, must leave a free slot.
  assign issue   = run && !br_pop &&
                   ((OW'(q_count) + OW'(vld_p1)) < (OW'(QDEPTH) + OW'(pop)));
  assign resolve = !run && (branch || bclr);
  assign taken   = b_cond[BO_UNCOND] | (cond_bit == b_cond[BO_COND_VAL]);
  assign target  = bclr ? lr[PC_W+1:2] : b_addr;

  // Stage 0: address issue
  assign imem_addr = fetch_pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FETCH_RUN;
      fetch_pc  <= PC_W'(RESET_PC);
      vld_p1    <= 1'b0;
      decode_en <= 1'b0;
      instr     <= '0;
      pc        <= '0;
    end else begin
      vld_p1    <= issue;
      decode_en <= pop;
      if (issue) fetch_pc <= fetch_pc + 1'b1;
      if (pop) begin
        instr <= q_instr;
        pc    <= q_pc;
      end
      if (br_pop) begin
        state <= FETCH_WAIT_BR;
      end else if (resolve) begin
        state    <= FETCH_RUN;
        fetch_pc <= taken ? target : pc + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (issue) pc_p1 <= fetch_pc;
  end

  // Stage 1: BRAM return, queue and bypass
  fetch_queue #(
    .PC_W   (PC_W),
    .QDEPTH (QDEPTH)
  ) u_queue (
    .clk       (clk),
    .rst       (rst),
    .flush     (br_pop),
    .in_vld    (vld_p1),
    .in_pc     (pc_p1),
    .in_instr  (imem_rdata),
    .pop       (pop),
    .out_vld   (q_vld),
    .out_pc    (q_pc),
    .out_instr (q_instr),
    .count     (q_count)
  );

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      br_count     <= '0;
      taken_count  <= '0;
      stall_cycles <= '0;
    end else begin
      if (resolve) begin
        br_count <= br_count + 1'b1;
        if (taken) taken_count <= taken_count + 1'b1;
      end
      if (stall && (q_count != '0)) stall_cycles <= stall_cycles + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch.sv
// Table-driven bench for fetch: one row per clock cycle with inputs and expected outputs.
module tb_fetch;

  logic        clk;
  logic        rst;
  logic [18:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        decode_en;
  logic [31:0] instr;
  logic [18:0] pc;
  logic        branch;
  logic        bclr;
  logic [18:0] b_addr;
  logic [4:0]  b_cond;
  logic        cond_bit;
  logic [31:0] lr;
`ifdef FETCH_PERF_EN
  logic [31:0] br_count, taken_count, stall_cycles;
`endif

  fetch dut (
    .clk        (clk),
    .rst        (rst),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .stall      (stall),
    .decode_en  (decode_en),
    .instr      (instr),
    .pc         (pc),
    .branch     (branch),
    .bclr       (bclr),
    .b_addr     (b_addr),
    .b_cond     (b_cond),
    .cond_bit   (cond_bit),
    .lr         (lr)
`ifdef FETCH_PERF_EN
    ,
    .br_count     (br_count),
    .taken_count  (taken_count),
    .stall_cycles (stall_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [31:0] W_B    = {6'd18, 26'd0};
  localparam logic [31:0] W_BC   = {6'd16, 26'd0};
  localparam logic [31:0] W_BCLR = {6'd19, 15'd0, 10'd16, 1'b0};

  // Program images: 0 straight line, 1 B at 2, 2 BC at 1, 3 BCLR at 0, 4 B at 1.
  function automatic logic [31:0] prog_word(input int prog, input logic [18:0] a);
    if (prog == 1 && a == 19'd2) return W_B;
    if (prog == 2 && a == 19'd1) return W_BC;
    if (prog == 3 && a == 19'd0) return W_BCLR;
    if (prog == 4 && a == 19'd1) return W_B;
    return {6'd4, 7'd0, a};
  endfunction

  logic [31:0] mem [256];
  always @(posedge clk) imem_rdata <= mem[imem_addr[7:0]];

  task automatic load_prog(input int prog);
    for (int k = 0; k < 256; k++) mem[k] = prog_word(prog, 19'(k));
  endtask

  typedef struct {
    logic        rst, stall, branch, bclr, cond_bit;
    logic [18:0] b_addr;
    logic [4:0]  b_cond;
    logic [31:0] lr;
    int          prog;
    logic        chk_de, exp_de, chk_pc;
    logic [18:0] exp_pc;
  } vec_t;

  vec_t vq[$];
  int total = 0;
  int bad = 0;

  task automatic add(input logic rst_i, stall_i, br_i, bclr_i, input logic [18:0] ba,
                     input logic [4:0] bc, input logic cb, input logic [31:0] lr_i,
                     input int prog, input logic cde, ede, cpc, input logic [18:0] epc);
    vec_t r;
    r.rst = rst_i; r.stall = stall_i; r.branch = br_i; r.bclr = bclr_i;
    r.b_addr = ba; r.b_cond = bc; r.cond_bit = cb; r.lr = lr_i; r.prog = prog;
    r.chk_de = cde; r.exp_de = ede; r.chk_pc = cpc; r.exp_pc = epc;
    vq.push_back(r);
  endtask

  // Two reset cycles, then cycle 0 (full reset-state check) and cycle 1 (still idle).
  task automatic boot(input int prog);
    add(1, 0, 0, 0, 0, 0, 0, 0, prog, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0, 0, prog, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, prog, 1, 0, 1, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, prog, 1, 0, 0, 0);
  endtask

  task automatic cyc(input int prog, input logic st, input logic de, input logic [18:0] epc);
    add(0, st, 0, 0, 0, 0, 0, 0, prog, 1, de, de, epc);
  endtask

  task automatic res(input int prog, input logic br_i, bclr_i, input logic [18:0] ba,
                     input logic [4:0] bc, input logic cb, input logic [31:0] lr_i,
                     input logic st);
    add(0, st, br_i, bclr_i, ba, bc, cb, lr_i, prog, 1, 0, 0, 0);
  endtask

  task automatic check(input string name, input int row, input logic [31:0] got,
                       input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s row%0d: got %h want %h", name, row, got, want);
    end
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; branch = 1'b0; bclr = 1'b0;
    b_addr = '0; b_cond = '0; cond_bit = 1'b0; lr = '0;
    load_prog(0);

    // Straight line; a branch pulse while running must be ignored.
    boot(0);
    cyc(0, 0, 1, 0); cyc(0, 0, 1, 1);
    add(0, 0, 1, 0, 'h40, 5'b10000, 0, 0, 0, 1, 1, 1, 2);
    cyc(0, 0, 1, 3); cyc(0, 0, 1, 4); cyc(0, 0, 1, 5);

    // Stall fills the queue; decode_en low in cycles 3..5, then 1,2,3,4 in order.
    boot(0);
    cyc(0, 1, 1, 0); cyc(0, 1, 0, 0); cyc(0, 1, 0, 0); cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 1); cyc(0, 0, 1, 2); cyc(0, 0, 1, 3); cyc(0, 0, 1, 4);

    // B at pc 2, resolved next cycle under stall; next issue pc 0x40 four cycles later.
    boot(1);
    cyc(1, 0, 1, 0); cyc(1, 0, 1, 1); cyc(1, 0, 1, 2);
    res(1, 1, 0, 'h40, 5'b10000, 0, 0, 1);
    cyc(1, 0, 0, 0); cyc(1, 0, 0, 0);
    cyc(1, 0, 1, 'h40); cyc(1, 0, 1, 'h41);

    // BC b_cond=01100, cond_bit=0: not taken, falls through to pc 2.
    boot(2);
    cyc(2, 0, 1, 0); cyc(2, 0, 1, 1);
    res(2, 1, 0, 'h20, 5'b01100, 0, 0, 0);
    cyc(2, 0, 0, 0); cyc(2, 0, 0, 0);
    cyc(2, 0, 1, 2); cyc(2, 0, 1, 3);

    // Same BC with cond_bit=1: taken to b_addr.
    boot(2);
    cyc(2, 0, 1, 0); cyc(2, 0, 1, 1);
    res(2, 1, 0, 'h20, 5'b01100, 1, 0, 0);
    cyc(2, 0, 0, 0); cyc(2, 0, 0, 0);
    cyc(2, 0, 1, 'h20); cyc(2, 0, 1, 'h21);

    // BCLR with lr=0x100 goes to word 0x40, ignoring b_addr.
    boot(3);
    cyc(3, 0, 1, 0);
    res(3, 0, 1, 'h7, 5'b10100, 0, 32'h100, 0);
    cyc(3, 0, 0, 0); cyc(3, 0, 0, 0);
    cyc(3, 0, 1, 'h40); cyc(3, 0, 1, 'h41);

    // Reset with a full queue: no stale word after release.
    boot(0);
    cyc(0, 1, 1, 0); cyc(0, 1, 0, 0); cyc(0, 1, 0, 0);
    boot(0);
    cyc(0, 0, 1, 0); cyc(0, 0, 1, 1); cyc(0, 0, 1, 2);

    // Reset while waiting on a branch restarts at RESET_PC.
    boot(4);
    cyc(4, 0, 1, 0); cyc(4, 0, 1, 1); cyc(4, 0, 0, 0);
    boot(4);
    cyc(4, 0, 1, 0); cyc(4, 0, 1, 1); cyc(4, 0, 0, 0);

    @(posedge clk); #1;
    for (int i = 0; i < vq.size(); i++) begin
      vec_t r;
      r = vq[i];
      rst = r.rst; stall = r.stall; branch = r.branch; bclr = r.bclr;
      b_addr = r.b_addr; b_cond = r.b_cond; cond_bit = r.cond_bit; lr = r.lr;
      if (r.rst) load_prog(r.prog);
      if (r.chk_de) check("decode_en", i, 32'(decode_en), 32'(r.exp_de));
      if (r.chk_pc) begin
        check("pc", i, 32'(pc), 32'(r.exp_pc));
        check("instr", i, instr, r.exp_de ? prog_word(r.prog, r.exp_pc) : 32'h0);
      end
      @(posedge clk); #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
